// File: rtl/cap_sense_scanner.sv
//------------------------------------------------------------------------------
// cap_sense_scanner
//   Scans NUM_SENSORS capacitive pads in parallel.  Each scan charges every pad
//   through the shared drive output for CHARGE_CYCLES cycles.  It then releases
//   the drive and times how long each pad takes to discharge.  A pad whose
//   discharge time reaches the threshold is reported as touched.
//
//   Optional feature macro: CAP_SENSE_DEBOUNCE_EN
//     defined   -> each touch_mask bit toggles only after 3 consecutive scans
//                  disagree with it
//     undefined -> touch_mask follows the raw compare result of every scan
//
// Ports
//   clock                   system clock, rising edge
//   reset                   asynchronous, active-low
//   enable                  high = scan continuously; low = finish current scan
//   threshold               touch threshold, sampled in the EVAL cycle
//   capacitive_sensors_in   raw asynchronous pad levels
//   capacitive_sensors_out  shared pad charge drive
//   touch_mask              registered per-pad touched flags
//   scan_done               one-cycle pulse together with a new touch_mask
//   count_sel               raw-count read select
//   count_data              latched count of pad count_sel (0 if out of range)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module cap_sense_scanner #(
  parameter int NUM_SENSORS   = 9,
  parameter int CHARGE_CYCLES = 16,
  parameter int COUNT_W       = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [COUNT_W-1:0]     threshold,
  input  logic [NUM_SENSORS-1:0] capacitive_sensors_in,
  output logic                   capacitive_sensors_out,
  output logic [NUM_SENSORS-1:0] touch_mask,
  output logic                   scan_done,
  input  logic [3:0]             count_sel,
  output logic [COUNT_W-1:0]     count_data
);

  localparam logic [COUNT_W-1:0] MAX_COUNT = {COUNT_W{1'b1}};
  localparam int                 CYC_W     = $clog2(CHARGE_CYCLES + 1);
  localparam logic [CYC_W-1:0]   CYC_LAST  = CYC_W'(CHARGE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CHARGE, MEASURE, EVAL} state_t;

  state_t                 state_q, state_d;
  logic                   armed_q;
  logic [CYC_W-1:0]       cyc_q, cyc_d;
  logic [COUNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SENSORS-1:0] sync_meta_q, sync_q;
  logic [NUM_SENSORS-1:0] latched_q, latched_d;
  logic [COUNT_W-1:0]     count_q [NUM_SENSORS];
  logic [COUNT_W-1:0]     count_d [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] touch_q, touch_d;
  logic                   scan_done_q, scan_done_d;
  logic [NUM_SENSORS-1:0] raw;
  logic [NUM_SENSORS-1:0] mask_eval;
  logic [NUM_SENSORS-1:0] sync_in;

  assign sync_in = sync_q;

  // Raw touch decision: a longer discharge means more pad capacitance.
  for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_raw
    assign raw[gi] = (count_q[gi] >= threshold);
  end

`ifdef CAP_SENSE_DEBOUNCE_EN
  // Per-pad count of consecutive scans whose raw result disagrees with touch_mask.
  logic [1:0] diff_q [NUM_SENSORS];
  logic [1:0] diff_d [NUM_SENSORS];

  always_comb begin
    mask_eval = touch_q;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      diff_d[i] = diff_q[i];
      if (state_q == EVAL) begin
        if (raw[i] != touch_q[i]) begin
          if (diff_q[i] == 2'd2) begin
            mask_eval[i] = raw[i];
            diff_d[i]    = 2'd0;
          end else begin
            diff_d[i] = diff_q[i] + 2'd1;
          end
        end else begin
          diff_d[i] = 2'd0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SENSORS; i++) diff_q[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_SENSORS; i++) diff_q[i] <= diff_d[i];
    end
  end
`else
  assign mask_eval = raw;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    cnt_d       = cnt_q;
    latched_d   = latched_q;
    touch_d     = touch_q;
    scan_done_d = 1'b0;
    for (int i = 0; i < NUM_SENSORS; i++) count_d[i] = count_q[i];

    case (state_q)
      IDLE: begin
        // armed_q holds off the first scan for one cycle after reset release.
        if (enable && armed_q) begin
          state_d = CHARGE;
          cyc_d   = '0;
        end
      end
      CHARGE: begin
        if (cyc_q == CYC_LAST) begin
          state_d   = MEASURE;
          cnt_d     = '0;
          latched_d = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      MEASURE: begin
        if (&latched_q) begin
          state_d = EVAL;
        end else begin
          // At timeout every pad still charged is latched at MAX_COUNT.
          for (int i = 0; i < NUM_SENSORS; i++) begin
            if (!latched_q[i] && (!sync_in[i] || (cnt_q == MAX_COUNT))) begin
              count_d[i]   = cnt_q;
              latched_d[i] = 1'b1;
            end
          end
          if (cnt_q == MAX_COUNT) begin
            state_d = EVAL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      EVAL: begin
        touch_d     = mask_eval;
        scan_done_d = 1'b1;
        if (enable) begin
          state_d = CHARGE;
          cyc_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      cyc_q       <= '0;
      cnt_q       <= '0;
      sync_meta_q <= '0;
      sync_q      <= '0;
      latched_q   <= '0;
      touch_q     <= '0;
      scan_done_q <= 1'b0;
      for (int i = 0; i < NUM_SENSORS; i++) count_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= 1'b1;
      cyc_q       <= cyc_d;
      cnt_q       <= cnt_d;
      sync_meta_q <= capacitive_sensors_in;
      sync_q      <= sync_meta_q;
      latched_q   <= latched_d;
      touch_q     <= touch_d;
      scan_done_q <= scan_done_d;
      for (int i = 0; i < NUM_SENSORS; i++) count_q[i] <= count_d[i];
    end
  end

  assign capacitive_sensors_out = (state_q == CHARGE);
  assign touch_mask             = touch_q;
  assign scan_done              = scan_done_q;

  always_comb begin
    count_data = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (int'(count_sel) == i) count_data = count_q[i];
    end
  end

endmodule

// File: tb/tb_cap_sense_scanner.sv
//------------------------------------------------------------------------------
// tb_cap_sense_scanner
//   Directed bench for cap_sense_scanner.  A pad emulator holds each pad high
//   while it is driven and for dly[i] cycles after the drive is released.
//   From those delays a scan-level model predicts each scan's counts, the
//   scan_done position and touch_mask.  One compare process checks the DUT
//   against the model every cycle.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cap_sense_scanner;

  localparam int NS     = 9;
  localparam int CHG    = 16;
  localparam int CW     = 10;
  localparam int MAXC   = 1023;
`ifdef CAP_SENSE_DEBOUNCE_EN
  localparam int DB_SCANS = 3;
`else
  localparam int DB_SCANS = 1;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [CW-1:0] threshold;
  logic [NS-1:0] pads;
  logic          capacitive_sensors_out;
  logic [NS-1:0] touch_mask;
  logic          scan_done;
  logic [3:0]    count_sel;
  logic [CW-1:0] count_data;

  cap_sense_scanner dut (
    .clock                 (clock),
    .reset                 (reset),
    .enable                (enable),
    .threshold             (threshold),
    .capacitive_sensors_in (pads),
    .capacitive_sensors_out(capacitive_sensors_out),
    .touch_mask            (touch_mask),
    .scan_done             (scan_done),
    .count_sel             (count_sel),
    .count_data            (count_data)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
  endtask

  // ---------------- pad emulator ----------------
  int dly [NS];       // <0: pad tied low; else cycles the pad stays high after drive release
  int pad_timer = 0;

  always @(negedge clock) begin
    if (capacitive_sensors_out) pad_timer = 0;
    else if (pad_timer < 100000) pad_timer++;
    for (int i = 0; i < NS; i++)
      pads[i] = (dly[i] < 0) ? 1'b0 :
                (capacitive_sensors_out ? 1'b1 : (pad_timer < dly[i]));
  end

  // count_sel sweeps all selects (including out-of-range) unless pinned
  bit sel_hold = 1'b0;
  always @(negedge clock) begin
    if (!sel_hold) count_sel = (count_sel == 4'd12) ? 4'd0 : count_sel + 4'd1;
  end

  // ---------------- scan-level model + compare ----------------
  int            m_cnt [NS];
  int            p_cnt [NS];
  int            m_db  [NS];
  logic [NS-1:0] m_mask;
  bit            busy, prev_out, exp_done, raw;
  int            rel, done_off, charge_len, c_max, exp_data;

  always @(posedge clock) begin
    #1;
    if (!reset) begin
      busy = 0; prev_out = 0; charge_len = 0; rel = 0; m_mask = '0;
      for (int i = 0; i < NS; i++) begin m_cnt[i] = 0; m_db[i] = 0; end
    end else begin
      if (prev_out && !capacitive_sensors_out) begin
        // Drive just released: the pads' discharge times fix this scan's result.
        chk("charge_len", charge_len, CHG);
        busy = 1; rel = 0; c_max = 0;
        for (int i = 0; i < NS; i++) begin
          // Two synchronizer stages plus the emulator's release latency give dly+1.
          p_cnt[i] = (dly[i] < 0) ? 0 : ((dly[i] + 1 > MAXC) ? MAXC : dly[i] + 1);
          if (p_cnt[i] > c_max) c_max = p_cnt[i];
        end
        done_off = (c_max == MAXC) ? MAXC + 2 : c_max + 3;
      end
      if (capacitive_sensors_out) charge_len++; else charge_len = 0;

      exp_done = busy && (rel == done_off);
      if (exp_done) begin
        for (int i = 0; i < NS; i++) begin
          m_cnt[i] = p_cnt[i];
          raw = (p_cnt[i] >= int'(threshold));
`ifdef CAP_SENSE_DEBOUNCE_EN
          if (raw != m_mask[i]) begin
            m_db[i]++;
            if (m_db[i] == 3) begin m_mask[i] = raw; m_db[i] = 0; end
          end else m_db[i] = 0;
`else
          m_mask[i] = raw;
`endif
        end
        busy = 0;
      end
      chk("scan_done", int'(scan_done), int'(exp_done));
      chk("touch_mask", int'(touch_mask), int'(m_mask));
      if (busy) chk("drive_low_in_measure", int'(capacitive_sensors_out), 0);
      else begin
        exp_data = (int'(count_sel) < NS) ? m_cnt[count_sel] : 0;
        chk("count_data", int'(count_data), exp_data);
      end
      if (busy) rel++;
      prev_out = capacitive_sensors_out;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(input int limit, output int waited);
    waited = 0;
    while (1) begin
      @(posedge clock); #1; waited++;
      if (scan_done) break;
      if (waited >= limit) begin
        n_total++;
        $display("FAIL wait_scan_done: no pulse within %0d cycles", limit);
        break;
      end
    end
  endtask

  task automatic wait_out(input logic lvl, input int limit, output int waited);
    waited = 0;
    while (1) begin
      @(posedge clock); #1; waited++;
      if (capacitive_sensors_out == lvl) break;
      if (waited >= limit) begin
        n_total++;
        $display("FAIL wait_drive: level %0d not seen within %0d cycles", lvl, limit);
        break;
      end
    end
  endtask

  task automatic read_cnt(input int sel, output int val);
    sel_hold = 1'b1; count_sel = 4'(sel); #1; val = int'(count_data); sel_hold = 1'b0;
  endtask

  task automatic idle_check(input string nm);
    int bad = 0;
    repeat (25) begin
      @(posedge clock); #1;
      if (capacitive_sensors_out || scan_done) bad++;
    end
    chk(nm, bad, 0);
  endtask

  // n scans, enable dropped during the last scan's CHARGE; meas = cycles from
  // drive release to scan_done in the last scan
  task automatic do_scans(input int n, output int meas);
    int w;
    @(negedge clock); enable = 1'b1;
    wait_out(1'b1, 10, w);
    meas = 0;
    for (int k = 1; k <= n; k++) begin
      if (k == n) begin
        @(negedge clock); enable = 1'b0;
        wait_out(1'b0, 40, w);
        wait_done(1200, meas);
      end else begin
        wait_done(1200, w);
      end
    end
    idle_check("idle_after_enable_drop");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w, v, meas;
    reset = 1'b0; enable = 1'b0; threshold = 10'd100; count_sel = 4'd0;
    for (int i = 0; i < NS; i++) dly[i] = -1;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_mask", int'(touch_mask), 0);
    chk("reset_drive", int'(capacitive_sensors_out), 0);
    $display("reset released");

    // Pads tied low: zero counts, fixed scan rate
    enable = 1'b1;
    wait_done(40, w);
    chk_rng("first_done_latency", w, 19, 22);
    wait_done(40, w);
    chk("done_period", w, 19);
    @(negedge clock); enable = 1'b0;
    wait_done(40, w);
    chk("done_period_last", w, 19);
    idle_check("idle_after_enable_drop");
    for (int i = 0; i < NS; i++) begin
      read_cnt(i, v);
      chk("held_low_count", v, 0);
    end
    chk("held_low_mask", int'(touch_mask), 0);
    $display("pads tied low: %0d-cycle scan period", 19);

    // Pad 4 slow (200), others fast (5), threshold 100
    for (int i = 0; i < NS; i++) dly[i] = 5;
    dly[4] = 200;
    for (int k = 1; k <= DB_SCANS; k++) begin
      do_scans(1, meas);
      chk("slow_pad_mask", int'(touch_mask), (k >= DB_SCANS) ? 16 : 0);
      $display("slow pad scan %0d: touch_mask=%b", k, touch_mask);
    end
    read_cnt(4, v); chk_rng("slow_pad_count", v, 200, 202);
    read_cnt(0, v); chk_rng("fast_pad_count", v, 5, 7);

    // Pad 0 never discharges: timeout
    dly[0] = 5000; dly[4] = 5;
    do_scans(DB_SCANS, meas);
    chk_rng("timeout_measure_len", meas, 1023, 1026);
    read_cnt(0, v);  chk("timeout_count", v, 1023);
    read_cnt(12, v); chk("sel_out_of_range", v, 0);
    chk("timeout_mask", int'(touch_mask), 1);
    $display("timeout scan: measure->done %0d cycles", meas);

    // Threshold equal to the count -> touched
    dly[0] = 5; dly[2] = 49; threshold = 10'd50;
    do_scans(DB_SCANS, meas);
    read_cnt(2, v); chk("boundary_count", v, 50);
    chk("th_equal_mask", int'(touch_mask), 4);
    $display("threshold == count: touch_mask=%b", touch_mask);

    // Reset pulsed mid-MEASURE
    dly[2] = 5; dly[4] = 200;
    @(negedge clock); enable = 1'b1;
    wait_out(1'b1, 10, w);
    wait_out(1'b0, 40, w);
    repeat (50) @(posedge clock);
    sel_hold = 1'b1; count_sel = 4'd2;
    #2;
    chk("pre_reset_count", int'(count_data), 6);
    reset = 1'b0;
    #1;
    chk("async_reset_drive", int'(capacitive_sensors_out), 0);
    chk("async_reset_mask", int'(touch_mask), 0);
    chk("async_reset_count", int'(count_data), 0);
    chk("async_reset_done", int'(scan_done), 0);
    sel_hold = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    $display("reset pulsed mid-measure");

    // Threshold = count+1 -> not touched; threshold glitch during MEASURE ignored
    dly[2] = 49; dly[4] = 5;
    @(negedge clock); enable = 1'b1;
    wait_out(1'b1, 10, w);
    @(negedge clock); enable = 1'b0;
    wait_out(1'b0, 40, w);
    repeat (5) @(negedge clock);
    threshold = 10'd0;
    repeat (10) @(negedge clock);
    threshold = 10'd51;
    wait_done(200, w);
    chk("th_above_mask", int'(touch_mask), 0);
    read_cnt(2, v); chk("restart_count", v, 50);
    idle_check("idle_after_enable_drop");
    $display("threshold == count+1: touch_mask=%b", touch_mask);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
